// File: rtl/cache_mem_port_arbiter_if.sv
// Bundle of cache-side and buffer-side signals around the shared memory-controller buffer port.
// The arbiter connects through the slave modport; caches and buffer drive through master.
interface cache_mem_port_arbiter_if #(
  parameter int BW_WORD_ADDR = 24
);
  logic [1:0]              req_i;
  logic [1:0]              req_block_i;
  logic [1:0]              rw_i;
  logic [BW_WORD_ADDR-1:0] add0_i;
  logic [BW_WORD_ADDR-1:0] add1_i;
  logic [1:0]              write_i;
  logic [1:0]              read_i;
  logic [31:0]             data0_i;
  logic [31:0]             data1_i;
  logic [1:0]              en_o;
  logic [1:0]              ready_req_o;
  logic [1:0]              ready_write_o;
  logic [1:0]              ready_read_o;
  logic                    ready_req_i;
  logic                    ready_write_i;
  logic                    ready_read_i;
  logic                    req_o;
  logic                    req_block_o;
  logic                    rw_o;
  logic [BW_WORD_ADDR-1:0] add_o;
  logic                    write_o;
  logic                    read_o;
  logic [31:0]             data_o;
  logic                    owner_o;
  logic                    busy_o;
  logic                    timeout_o;

  modport slave (
    input  req_i, req_block_i, rw_i, add0_i, add1_i, write_i, read_i, data0_i, data1_i,
    input  ready_req_i, ready_write_i, ready_read_i,
    output en_o, ready_req_o, ready_write_o, ready_read_o,
    output req_o, req_block_o, rw_o, add_o, write_o, read_o, data_o,
    output owner_o, busy_o, timeout_o
  );

  modport master (
    output req_i, req_block_i, rw_i, add0_i, add1_i, write_i, read_i, data0_i, data1_i,
    output ready_req_i, ready_write_i, ready_read_i,
    input  en_o, ready_req_o, ready_write_o, ready_read_o,
    input  req_o, req_block_o, rw_o, add_o, write_o, read_o, data_o,
    input  owner_o, busy_o, timeout_o
  );
endinterface

// File: rtl/cache_mem_port_arbiter.sv
// Round-robin arbiter giving the I-cache (0) or D-cache (1) exclusive use of the shared
// buffer port for one whole command, with a watchdog that aborts hung transfers.
module cache_mem_port_arbiter #(
  parameter int BW_WORD_ADDR = 24,
  parameter int BW_BLOCK     = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic                   clock_i,
  input  logic                   resetn_i,
  cache_mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  localparam logic [BW_BLOCK:0] ONE_WORD    = 1;
  localparam logic [BW_BLOCK:0] BLOCK_WORDS = {1'b1, {BW_BLOCK{1'b0}}};
  localparam logic [15:0]       WDOG_LAST   = 16'(TIMEOUT - 1);

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              rw_q;
  logic              timeout_q;
  logic [BW_BLOCK:0] beat_cnt;
  logic [BW_BLOCK:0] target;
  logic [15:0]       wdog;
  logic              pick;
  logic              beat;

  // On a tie the cache that did not own the port last time wins.
  assign pick = (bus.req_i == 2'b11) ? ~last_owner : bus.req_i[1];
  assign beat = rw_q ? (bus.write_i[owner] & bus.ready_write_i)
                     : (bus.read_i[owner]  & bus.ready_read_i);

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      rw_q       <= 1'b0;
      timeout_q  <= 1'b0;
      beat_cnt   <= '0;
      target     <= '0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_i) begin
            owner <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (bus.req_i[owner] && bus.ready_req_i) begin
            rw_q     <= bus.rw_i[owner];
            target   <= bus.req_block_i[owner] ? BLOCK_WORDS : ONE_WORD;
            beat_cnt <= '0;
            wdog     <= '0;
            state    <= XFER;
          end else if (!bus.req_i[owner]) begin
            state <= IDLE;
          end
        end
        XFER: begin
          // The watchdog abort wins over a beat landing in the same cycle.
          if (wdog == WDOG_LAST) begin
            timeout_q  <= 1'b1;
            last_owner <= owner;
            state      <= IDLE;
          end else begin
            wdog <= wdog + 16'd1;
            if (beat) begin
              beat_cnt <= beat_cnt + ONE_WORD;
              if (beat_cnt + ONE_WORD == target) begin
                last_owner <= owner;
                state      <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.en_o          = '0;
    bus.ready_req_o   = '0;
    bus.ready_write_o = '0;
    bus.ready_read_o  = '0;
    bus.req_o         = 1'b0;
    bus.req_block_o   = 1'b0;
    bus.rw_o          = 1'b0;
    bus.add_o         = '0;
    bus.write_o       = 1'b0;
    bus.read_o        = 1'b0;
    bus.data_o        = '0;
    case (state)
      GRANT: begin
        bus.en_o[owner]        = 1'b1;
        bus.ready_req_o[owner] = bus.ready_req_i;
        bus.req_o              = bus.req_i[owner];
        bus.req_block_o        = bus.req_block_i[owner];
        bus.rw_o               = bus.rw_i[owner];
        bus.add_o              = owner ? bus.add1_i : bus.add0_i;
      end
      XFER: begin
        // Only the strobe matching the latched direction is forwarded.
        bus.en_o[owner]          = 1'b1;
        bus.ready_write_o[owner] = bus.ready_write_i;
        bus.ready_read_o[owner]  = bus.ready_read_i;
        bus.write_o              = rw_q & bus.write_i[owner];
        bus.read_o               = ~rw_q & bus.read_i[owner];
        bus.data_o               = owner ? bus.data1_i : bus.data0_i;
      end
      default: ;
    endcase
  end

  assign bus.owner_o   = owner;
  assign bus.busy_o    = (state != IDLE);
  assign bus.timeout_o = timeout_q;

endmodule
